// File: rtl/mux_rr_nw_pkg.sv
// Shared types and helpers for the round-robin registered multiplexer.
// The packet-lock state type is only instantiated when MUX_RR_LOCK_EN is defined.
package mux_rr_pkg;

  localparam int LOCK_CH_W = 16;

  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 lock;
    logic [LOCK_CH_W-1:0] lock_ch;
  } lock_st_t;

endpackage

// File: rtl/mux_rr_nw_if.sv
// Handshake bundle between N producer channels, the mux, and one consumer.
// slave is the mux side; master is the producer/consumer side.
interface mux_rr_nw_if
  import mux_rr_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N)
);

  logic [N-1:0]     in_valid;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_last;
  logic [N-1:0]     in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sel
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sel
  );

endinterface

// File: rtl/mux_rr_nw_arbiter.sv
// Round-robin arbiter: searches from ptr upward with wrap, owns the ptr register.
module rr_arbiter
  import mux_rr_pkg::*;
#(
  parameter int N     = 4,
  parameter int SEL_W = sel_width(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] grant,
  output logic             any
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int               pos;
    logic [SEL_W-1:0] idx;
    grant = '0;
    any   = 1'b0;
    pos   = 0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= N) pos = pos - N;
      idx = SEL_W'(pos);
      if (req[idx]) begin
        grant = idx;
        any   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (advance) begin
      ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
    end
  end

endmodule

// File: rtl/mux_rr_nw.sv
// N-channel registered mux with round-robin channel selection and valid/ready on both sides.
// Define MUX_RR_LOCK_EN to hold the grant on one channel until it sends a beat with in_last set.
module mux_rr_nw
  import mux_rr_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int SEL_W = sel_width(N)
) (
  input logic           clk,
  input logic           rst,
  mux_rr_nw_if.slave    bus
);

  logic [N-1:0]     req;
  logic [SEL_W-1:0] ptr;
  logic [SEL_W-1:0] grant;
  logic             any;
  logic             load;
  logic             xfer;
  logic             advance;

  logic             out_valid_q;
  logic [W-1:0]     out_data_q;
  logic [SEL_W-1:0] out_sel_q;

  assign load = ~out_valid_q | bus.out_ready;
  assign xfer = load & any;

`ifdef MUX_RR_LOCK_EN
  lock_st_t lock_q;
  logic     unused_lock_hi;

  assign unused_lock_hi = ^lock_q.lock_ch[LOCK_CH_W-1:SEL_W];

  // While locked only the locked channel may request, so the arbiter grants it or nothing.
  assign req     = lock_q.lock ? (bus.in_valid & (N'(1) << lock_q.lock_ch[SEL_W-1:0]))
                               : bus.in_valid;
  assign advance = xfer & bus.in_last[grant];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_q <= '0;
    end else if (xfer) begin
      lock_q.lock    <= ~bus.in_last[grant];
      lock_q.lock_ch <= LOCK_CH_W'(grant);
    end
  end
`else
  logic unused_last;

  assign unused_last = ^bus.in_last;
  assign req         = bus.in_valid;
  assign advance     = xfer;
`endif

  rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .ptr     (ptr),
    .grant   (grant),
    .any     (any)
  );

  always_comb begin
    bus.in_ready = '0;
    if (xfer) bus.in_ready[grant] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
    end else if (load) begin
      out_valid_q <= any;
      if (any) begin
        out_data_q <= bus.in_data[grant*W +: W];
        out_sel_q  <= grant;
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule

// File: doc/mux_rr_nw.md
# mux_rr_nw

Parametrised N-channel, W-bit registered multiplexer with per-channel valid/ready handshake and round-robin channel selection. It replaces the fixed 4:1 combinational select mux: the select is generated internally by a fair arbiter instead of a `sel` input, and the output passes through one register stage. It sits between several producer channels and a single downstream consumer, with backpressure on both sides.

## Interface
- `N`, 4: number of input channels, ≥2.
- `W`, 8: data width per channel, ≥1.
- `SEL_W`, $clog2(N): width of the channel index. Derived; do not override.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  N  per-channel valid.
- `in_data`  in  N*W  channel i occupies bits [i*W +: W].
- `in_last`  in  N  per-channel end-of-packet. Used only when `MUX_RR_LOCK_EN` is defined; ignored otherwise.
- `in_ready`  out  N  per-channel accept, one-hot or zero.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  W  registered data.
- `out_sel`  out  SEL_W  index of the channel that supplied `out_data`.
- `out_ready`  in  1  consumer accept.

## Operation
- **Arbiter pointer:** `ptr` (SEL_W bits) marks the highest-priority channel.
- **Grant:** combinational search from `ptr` upward, wrapping at N-1 → 0. The first channel with `in_valid` wins.
- **Load enable:** `load = ~out_valid | out_ready`.
- **Ready:** `in_ready[g] = load & any_valid` for the granted channel g. All other `in_ready` bits are 0.
- **Input transfer:** occurs on `in_valid[g] & in_ready[g]`.
- **On each rising edge:**
  - If `load` is high: `out_valid <= any_valid`. On a transfer, `out_data <= in_data[g]` and `out_sel <= g`.
  - If `load` is low: all output registers hold.
- **Pointer update on transfer:** `ptr <= (g == N-1) ? 0 : g+1`. No transfer means `ptr` holds.
- **Idle:** with no `in_valid`, grant is undefined, `in_ready` is 0, and `ptr` holds.
- **Output transfer:** `out_valid & out_ready`. A new beat may load in the same cycle, so full throughput is 1 beat/cycle.
- **Data stability:** `out_data` and `out_sel` are stable while `out_valid & ~out_ready`.
- **Data width:** data passes unmodified. No arithmetic on data.

## Timing
- **Reset values** (immediately on `rst` assertion, independent of `clk`): `out_valid=0`, `out_data=0`, `out_sel=0`, `ptr=0`, lock state cleared.
- **Reset mid-operation:** the held beat is discarded. `in_ready` goes to 0 combinationally only via `out_valid`/`any_valid`, with no registered ready.
- **Latency:** 1 cycle from input transfer to `out_valid`.
- **Bubble-free:** back-to-back beats from different channels are carried on consecutive cycles.
- **Simultaneous requests:** served in rotating order. No channel waits more than N-1 transfers.
- **Stall:** `out_ready=0` with `out_valid=1` forces all `in_ready` low. Grant may change during the stall, and the winner is re-evaluated on the cycle `load` rises.
- **Combinational paths:** only `out_ready → in_ready`, and `in_valid → in_ready`.

## Configuration
- **`MUX_RR_LOCK_EN` defined** (packet lock):
  - After a transfer with `in_last[g]=0`, a `lock` flag is set and `lock_ch <= g`.
  - While locked, grant is forced to `lock_ch` whether or not other channels are valid. No transfer occurs while `in_valid[lock_ch]=0`.
  - A transfer with `in_last=1` clears `lock` and advances `ptr` as normal.
  - While locked, `ptr` does not advance.
- **`MUX_RR_LOCK_EN` undefined:** every beat is arbitrated independently. `in_last` is unused and no lock registers exist.

## Structure
- **Package `mux_rr_pkg`:** a constant function for SEL_W (clog2 with a minimum of 1), plus the lock-state struct type (`lock`, `lock_ch`).
- **Sub-module `rr_arbiter`** (N, SEL_W):
  - Inputs: `req[N]`, `ptr`, `advance`.
  - Outputs: grant index, `any`.
  - Owns the `ptr` register and the wrap logic.
- **Top level:** the load enable, the output register, and the optional lock.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle while `out_valid=1` → `out_valid`, `out_data`, `out_sel` are 0 before the next edge. After release, channel 0 is highest priority.
- **All channels busy:** N=4, all `in_valid=1`, data 0xA0–0xA3, `out_ready=1` → `out_sel` sequence 0,1,2,3,0 on consecutive cycles, with `out_data` matching and no bubbles.
- **Partial requesters:** only ch1 and ch3 valid → alternating 1,3,1,3. Ch3 is granted after ch1 even though `ptr=2`, which checks wrap from 3 to 0 and skip.
- **Backpressure:** hold `out_ready=0` for 3 cycles with beat 0x55 from ch2 → `out_data` stays 0x55, `out_sel` stays 2, and `in_ready` stays 0. On release, the next channel (3) is accepted in the same cycle.
- **Single channel:** only ch0 valid, 5 beats → 5 consecutive transfers, each with `out_sel=0`.
- **With `MUX_RR_LOCK_EN`:** ch1 sends 3 beats (last on the 3rd) while ch0 and ch2 are also valid → `out_sel` is 1,1,1, then 2. The same stimulus without the macro gives 1,2,0.
